// File: rtl/packet_disassembler_arbiter_pkg.sv
// Shared types and sizing helpers for the packet disassembler arbiter.
// Holds the FSM state enum and the derived-width helper functions.
package packet_disassembler_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic int calc_num_chunks(
    input int nin,
    input int nout
  );
    return (nin + nout - 1) / nout;
  endfunction

  function automatic int calc_id_bits(
    input int n
  );
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/packet_disassembler_arbiter_if.sv
// Handshake bundle between requesters, the arbiter and the disassembler.
// slave: arbiter side; master: environment (requesters + disassembler).
interface packet_disassembler_arbiter_if
  import packet_disassembler_arbiter_pkg::*;
#(
  parameter int nreqs    = 2,
  parameter int nbits_in = 16,
  parameter int id_bits  = calc_id_bits(nreqs)
);

  logic [nreqs-1:0]          req_val;
  logic [nreqs-1:0]          req_rdy;
  logic [nreqs*nbits_in-1:0] req_msg;
  logic                      dis_recv_val;
  logic                      dis_recv_rdy;
  logic [nbits_in-1:0]       dis_recv_msg;
  logic                      dis_send_val;
  logic                      dis_send_rdy;
  logic [id_bits-1:0]        send_src;
  logic                      send_last;

  modport slave (
    input  req_val, req_msg,
    input  dis_recv_rdy,
    input  dis_send_val, dis_send_rdy,
    output req_rdy,
    output dis_recv_val, dis_recv_msg,
    output send_src, send_last
  );

  modport master (
    output req_val, req_msg,
    output dis_recv_rdy,
    output dis_send_val, dis_send_rdy,
    input  req_rdy,
    input  dis_recv_val, dis_recv_msg,
    input  send_src, send_last
  );

endinterface

// File: rtl/packet_disassembler_arbiter_rr_priority_picker.sv
// Round-robin picker: first set req bit scanning from prio upward (mod n).
// Ports: req, prio in; gnt (one-hot), gnt_id, any out. Purely combinational.
module rr_priority_picker #(
  parameter int nreqs   = 2,
  parameter int id_bits = 1
) (
  input  logic [nreqs-1:0]   req,
  input  logic [id_bits-1:0] prio,
  output logic [nreqs-1:0]   gnt,
  output logic [id_bits-1:0] gnt_id,
  output logic               any
);

  int   idx;
  logic found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < nreqs; k++) begin
      idx = (int'(prio) + k) % nreqs;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = id_bits'(idx);
      end
    end
    any = found;
  end

endmodule

// File: rtl/packet_disassembler_arbiter.sv
// Round-robin arbiter sharing one packet disassembler among nreqs sources.
// Ports: clk, reset (sync, active-high), bus (slave modport of the bundle).
module packet_disassembler_arbiter
  import packet_disassembler_arbiter_pkg::*;
#(
  parameter int nreqs     = 2,
  parameter int nbits_in  = 16,
  parameter int nbits_out = 8
) (
  input logic clk,
  input logic reset,
  packet_disassembler_arbiter_if.slave bus
);

  localparam int NUM_CHUNKS = calc_num_chunks(nbits_in, nbits_out);
  localparam int ID_BITS    = calc_id_bits(nreqs);
  localparam int CNT_W      = $clog2(NUM_CHUNKS) + 1;

  state_e             state_q, state_d;
  logic [ID_BITS-1:0] prio_q, prio_d;
  logic [ID_BITS-1:0] cur_id_q, cur_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [nreqs-1:0]    gnt;
  logic [ID_BITS-1:0]  gnt_id;
  logic                any_req;
  logic [nbits_in-1:0] win_msg;
  logic                fire;
  logic                at_last;

  rr_priority_picker #(
    .nreqs  (nreqs),
    .id_bits(ID_BITS)
  ) u_pick (
    .req   (bus.req_val),
    .prio  (prio_q),
    .gnt   (gnt),
    .gnt_id(gnt_id),
    .any   (any_req)
  );

  // One-hot grant lets the mux use constant slices only.
  always_comb begin
    win_msg = '0;
    for (int i = 0; i < nreqs; i++) begin
      if (gnt[i]) win_msg |= bus.req_msg[i*nbits_in +: nbits_in];
    end
  end

  assign fire    = bus.dis_send_val & bus.dis_send_rdy;
  assign at_last = (cnt_q == CNT_W'(NUM_CHUNKS - 1));

  always_comb begin
    state_d          = state_q;
    prio_d           = prio_q;
    cur_id_d         = cur_id_q;
    cnt_d            = cnt_q;
    bus.req_rdy      = '0;
    bus.dis_recv_val = 1'b0;
    bus.dis_recv_msg = '0;
    bus.send_src     = '0;
    bus.send_last    = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          bus.dis_recv_val = any_req;
          bus.dis_recv_msg = win_msg;
          bus.req_rdy      = gnt & {nreqs{bus.dis_recv_rdy}};
          if (any_req && bus.dis_recv_rdy) begin
            state_d  = BUSY;
            cur_id_d = gnt_id;
            cnt_d    = '0;
          end
        end
        BUSY: begin
          bus.send_src  = cur_id_q;
          bus.send_last = at_last;
          if (fire) begin
            if (at_last) begin
              state_d = IDLE;
              cnt_d   = '0;
              prio_d  = ID_BITS'((int'(cur_id_q) + 1) % nreqs);
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      prio_q   <= '0;
      cur_id_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      cur_id_q <= cur_id_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_packet_disassembler_arbiter.sv
// Directed bench: per-cycle vector table plus hand sequences.
// Second instance covers the 12->8 uneven-width configuration.
module tb_packet_disassembler_arbiter;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  packet_disassembler_arbiter_if #(
    .nreqs(2), .nbits_in(16), .id_bits(1)
  ) bus ();

  packet_disassembler_arbiter_if #(
    .nreqs(2), .nbits_in(12), .id_bits(1)
  ) bus12 ();

  packet_disassembler_arbiter #(
    .nreqs(2), .nbits_in(16), .nbits_out(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  packet_disassembler_arbiter #(
    .nreqs(2), .nbits_in(12), .nbits_out(8)
  ) dut12 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus12)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  rv;
    logic [15:0] m0;
    logic [15:0] m1;
    logic [1:0]  erdy;
    logic        eval;
    logic [15:0] emsg;
    logic        esrc;
    logic        elast;
  } vec_t;

  vec_t vecs[19];
  int   n_pass;
  int   n_total;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic [1:0] rv,
                       input logic [15:0] m0, input logic [15:0] m1,
                       input logic rrdy, input logic sv,
                       input logic sr);
    reset            = rst;
    bus.req_val      = rv;
    bus.req_msg      = {m1, m0};
    bus.dis_recv_rdy = rrdy;
    bus.dis_send_val = sv;
    bus.dis_send_rdy = sr;
    #1;
  endtask

  task automatic expect_o(input string tag, input logic [1:0] erdy,
                          input logic eval, input logic [15:0] emsg,
                          input logic esrc, input logic elast);
    chk({tag, ".req_rdy"}, 32'(bus.req_rdy), 32'(erdy));
    chk({tag, ".recv_val"}, 32'(bus.dis_recv_val), 32'(eval));
    chk({tag, ".recv_msg"}, 32'(bus.dis_recv_msg), 32'(emsg));
    chk({tag, ".send_src"}, 32'(bus.send_src), 32'(esrc));
    chk({tag, ".send_last"}, 32'(bus.send_last), 32'(elast));
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    vecs = '{
      '{1'b1, 2'b01, 16'hABCD, 16'h2222, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0},
      '{1'b0, 2'b01, 16'hABCD, 16'h2222, 2'b01, 1'b1, 16'hABCD, 1'b0, 1'b0},
      '{1'b0, 2'b01, 16'hABCD, 16'h2222, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0},
      '{1'b0, 2'b01, 16'hABCD, 16'h2222, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b1},
      '{1'b0, 2'b00, 16'hABCD, 16'h2222, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0},
      '{1'b1, 2'b11, 16'h1111, 16'h2222, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0},
      '{1'b0, 2'b11, 16'h1111, 16'h2222, 2'b01, 1'b1, 16'h1111, 1'b0, 1'b0},
      '{1'b0, 2'b11, 16'h1111, 16'h2222, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0},
      '{1'b0, 2'b11, 16'h1111, 16'h2222, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b1},
      '{1'b0, 2'b11, 16'h1111, 16'h2222, 2'b10, 1'b1, 16'h2222, 1'b0, 1'b0},
      '{1'b0, 2'b11, 16'h1111, 16'h2222, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b0},
      '{1'b0, 2'b11, 16'h1111, 16'h2222, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b1},
      '{1'b0, 2'b11, 16'h1111, 16'h2222, 2'b01, 1'b1, 16'h1111, 1'b0, 1'b0},
      '{1'b0, 2'b11, 16'h1111, 16'h2222, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0},
      '{1'b0, 2'b11, 16'h1111, 16'h2222, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b1},
      '{1'b0, 2'b11, 16'h1111, 16'h2222, 2'b10, 1'b1, 16'h2222, 1'b0, 1'b0},
      '{1'b0, 2'b11, 16'h1111, 16'h2222, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b0},
      '{1'b0, 2'b11, 16'h1111, 16'h2222, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b1},
      '{1'b0, 2'b00, 16'h1111, 16'h2222, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0}
    };

    bus12.req_val      = '0;
    bus12.req_msg      = '0;
    bus12.dis_recv_rdy = 1'b0;
    bus12.dis_send_val = 1'b0;
    bus12.dis_send_rdy = 1'b0;
    drive(1'b1, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    tick();

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].m0, vecs[i].m1,
            1'b1, 1'b1, 1'b1);
      expect_o($sformatf("vec%0d", i), vecs[i].erdy, vecs[i].eval,
               vecs[i].emsg, vecs[i].esrc, vecs[i].elast);
      tick();
    end

    // Backpressure: prio is 0 here, req0 wins.
    drive(1'b0, 2'b01, 16'hBEEF, 16'hCAFE, 1'b1, 1'b1, 1'b1);
    expect_o("bp_grant", 2'b01, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b11, 16'hBEEF, 16'hCAFE, 1'b1, 1'b1, 1'b0);
      expect_o($sformatf("bp_stall0_%0d", i), 2'b00, 1'b0, 16'h0,
               1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 2'b11, 16'hBEEF, 16'hCAFE, 1'b1, 1'b1, 1'b1);
    expect_o("bp_chunk0", 2'b00, 1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 2'b11, 16'hBEEF, 16'hCAFE, 1'b1, 1'b1, 1'b0);
      expect_o($sformatf("bp_stall1_%0d", i), 2'b00, 1'b0, 16'h0,
               1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 2'b11, 16'hBEEF, 16'hCAFE, 1'b1, 1'b1, 1'b1);
    expect_o("bp_chunk1", 2'b00, 1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 2'b11, 16'hBEEF, 16'hCAFE, 1'b1, 1'b1, 1'b1);
    expect_o("bp_next_grant", 2'b10, 1'b1, 16'hCAFE, 1'b0, 1'b0);
    tick();

    // Reset mid-packet while serving req1 (prio currently 1).
    drive(1'b0, 2'b11, 16'hBEEF, 16'hCAFE, 1'b1, 1'b1, 1'b1);
    expect_o("rst_chunk0", 2'b00, 1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 2'b11, 16'hBEEF, 16'hCAFE, 1'b1, 1'b1, 1'b1);
    expect_o("rst_hold", 2'b00, 1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'b11, 16'hBEEF, 16'hCAFE, 1'b0, 1'b0, 1'b0);
    expect_o("rst_prio0", 2'b00, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'b10, 16'hBEEF, 16'hCAFE, 1'b1, 1'b1, 1'b1);
    expect_o("rst_req1", 2'b10, 1'b1, 16'hCAFE, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'b10, 16'hBEEF, 16'hCAFE, 1'b1, 1'b1, 1'b1);
    expect_o("rst_req1_c0", 2'b00, 1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 2'b00, 16'hBEEF, 16'hCAFE, 1'b1, 1'b1, 1'b1);
    expect_o("rst_req1_c1", 2'b00, 1'b0, 16'h0, 1'b1, 1'b1);
    tick();

    // Spurious chunk handshakes while idle.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 2'b00, 16'hBEEF, 16'hCAFE, 1'b1, 1'b1, 1'b1);
      expect_o($sformatf("spur_%0d", i), 2'b00, 1'b0, 16'h0,
               1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 2'b01, 16'h5A5A, 16'hCAFE, 1'b1, 1'b1, 1'b1);
    expect_o("spur_grant", 2'b01, 1'b1, 16'h5A5A, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'b00, 16'h5A5A, 16'hCAFE, 1'b1, 1'b1, 1'b1);
    expect_o("spur_c0", 2'b00, 1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'b00, 16'h5A5A, 16'hCAFE, 1'b1, 1'b1, 1'b1);
    expect_o("spur_c1", 2'b00, 1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 2'b00, 16'h5A5A, 16'hCAFE, 1'b1, 1'b1, 1'b1);
    expect_o("spur_idle", 2'b00, 1'b0, 16'h0, 1'b0, 1'b0);
    tick();

    // Uneven widths: 12-bit packet in two 8-bit chunks.
    bus12.req_val      = 2'b01;
    bus12.req_msg      = {12'h000, 12'hABC};
    bus12.dis_recv_rdy = 1'b1;
    bus12.dis_send_val = 1'b1;
    bus12.dis_send_rdy = 1'b1;
    #1;
    chk("u12.req_rdy", 32'(bus12.req_rdy), 32'h1);
    chk("u12.recv_val", 32'(bus12.dis_recv_val), 32'h1);
    chk("u12.recv_msg", 32'(bus12.dis_recv_msg), 32'hABC);
    tick();
    bus12.req_val = 2'b00;
    #1;
    chk("u12.c0_last", 32'(bus12.send_last), 32'h0);
    chk("u12.c0_val", 32'(bus12.dis_recv_val), 32'h0);
    tick();
    chk("u12.c1_last", 32'(bus12.send_last), 32'h1);
    tick();
    chk("u12.idle_last", 32'(bus12.send_last), 32'h0);
    chk("u12.idle_val", 32'(bus12.dis_recv_val), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/packet_disassembler_arbiter.md
Name: packet_disassembler_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one packet disassembler (wide packet in, nbits_out chunks out, MSB chunk first) among nreqs wide-packet requesters.
- Grants one requester and forwards its packet to the disassembler receive interface.
- Holds the grant locked until the disassembler has emitted every chunk of that packet.
- Tags each outgoing chunk with its source id and a last-chunk flag. Sits between the SPI transmit sources and the shared disassembler.

Parameters:
- nreqs, 2, number of requesters (>=1).
- nbits_in, 16, width of the wide packet.
- nbits_out, 8, disassembler chunk width (nbits_out < nbits_in).
- num_chunks, derived = ceil(nbits_in/nbits_out), chunks per packet; never set by the user.
- id_bits, derived = max(1, $clog2(nreqs)), width of the source id; never set by the user.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_val  input  nreqs  per-requester valid.
- req_rdy  output  nreqs  per-requester ready.
- req_msg  input  nreqs*nbits_in  packed requester packets; requester i occupies bits [i*nbits_in +: nbits_in].
- dis_recv_val  output  1  valid to the disassembler receive port.
- dis_recv_rdy  input  1  ready from the disassembler receive port.
- dis_recv_msg  output  nbits_in  packet to the disassembler.
- dis_send_val  input  1  monitored disassembler output valid.
- dis_send_rdy  input  1  monitored downstream ready on the disassembler output.
- send_src  output  id_bits  source id of the chunk now on the disassembler output.
- send_last  output  1  high when the current chunk is the final chunk of its packet.

Behaviour:
- State: state in {IDLE, BUSY}; prio pointer (id_bits); cur_id (id_bits); chunk counter cnt (width $clog2(num_chunks)+1).
- Reset values: state=IDLE, prio=0, cur_id=0, cnt=0. While reset is high, all outputs are 0.
- IDLE, arbitration: combinational round-robin pick of the first asserted req_val[i], scanning i = prio, prio+1, ... modulo nreqs. The winner is w.
  - dis_recv_val = any(req_val).
  - dis_recv_msg = req_msg[w].
  - req_rdy[w] = dis_recv_rdy. All other req_rdy bits are 0.
  - With no valid requests, dis_recv_val=0 and dis_recv_msg=0.
- IDLE, accept: when dis_recv_val & dis_recv_rdy, the request is accepted. The same cycle is the requester handshake. Next cycle: state=BUSY, cur_id=w, cnt=0.
- BUSY outputs: req_rdy=0, dis_recv_val=0, send_src=cur_id, send_last=(cnt==num_chunks-1).
- BUSY counting: each cycle with dis_send_val & dis_send_rdy is a chunk fire.
  - If cnt<num_chunks-1: cnt increments.
  - If cnt==num_chunks-1: next state=IDLE, cnt=0, prio=(cur_id+1) mod nreqs.
- Latency: a new grant is possible no earlier than 1 cycle after the last chunk fires. This matches the disassembler's 1-cycle ready recovery.
- IDLE outputs: send_src=0, send_last=0. A chunk fire seen in IDLE is ignored, and state and cnt are unchanged.
- Lock: the grant is never revoked in BUSY. Requesters whose req_val rises or drops during BUSY have no effect until the next IDLE. Dropping req_val in IDLE before acceptance is legal and simply re-arbitrates.
- Fairness: after serving i, requester i is lowest priority. With all requesters valid continuously, grants rotate 0,1,...,nreqs-1,0.
- dis_send_rdy low in BUSY stalls cnt. There is no timeout.
- nreqs=1: prio stays 0 and the block degenerates to a packet-count sequencer.
- Reset mid-packet: next cycle is IDLE with prio=0. The disassembler shares the reset, so no partial packet survives.

Decomposition:
- Shared package holds:
  - State enum {IDLE, BUSY}.
  - Helper functions for num_chunks (ceiling divide) and id_bits (clog2 clamped to a minimum of 1).
- One natural sub-module, rr_priority_picker: combinational, inputs req vector and prio pointer, outputs one-hot grant plus encoded id. It is reusable by other SPI arbiters.

Test Plan:
- Single request, nreqs=2, 16->8: req_val=01, msg0=0xABCD, rdy always high.
  - Required: req_rdy[0] for 1 cycle, dis_recv_msg=0xABCD.
  - Then chunks 0xAB (src=0, last=0) and 0xCD (src=0, last=1), then IDLE.
- Round-robin: both requesters held valid with msg0=0x1111, msg1=0x2222 for 4 packets.
  - Required: grant order 0,1,0,1.
  - Required: send_src sequence 0,0,1,1,0,0,1,1; req_rdy never asserted in BUSY.
- Backpressure: dis_send_rdy low for 3 cycles mid-packet.
  - Required: cnt frozen and send_last held 0 on the first chunk.
  - Required: no new grant until the final chunk fires.
- Uneven widths, nbits_in=12, nbits_out=8: msg=0xABC.
  - Required: num_chunks=2, chunks 0x0A then 0xBC, last asserted on the second.
- Reset mid-packet: assert reset after the first chunk.
  - Required: next cycle IDLE, all outputs 0, prio=0.
  - Required: a subsequent req1-only request is granted normally.
- Spurious chunk handshake in IDLE: pulse dis_send_val & dis_send_rdy with no grant.
  - Required: state, cnt and send_last unchanged.
